// File: rtl/mem_wb_skid_reg.sv
// MEM->WB boundary register with a two-entry skid buffer; an entry accepted at edge N drives the W outputs after edge N.
// Backpressure: ReadyM falls only when both entries are full, and is never combinationally derived from ReadyW.
module mem_wb_skid_reg #(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RESULT_SRC_WIDTH = 2,
  parameter int STALL_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        ValidM,
  output logic                        ReadyM,
  input  logic [DATA_WIDTH-1:0]       ALUResultM,
  input  logic [DATA_WIDTH-1:0]       ReadDataM,
  input  logic [REG_ADDR_WIDTH-1:0]   RdM,
  input  logic [DATA_WIDTH-1:0]       PCPlus4M,
  input  logic                        RegWriteM,
  input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
  output logic                        ValidW,
  input  logic                        ReadyW,
  output logic [DATA_WIDTH-1:0]       ALUResultW,
  output logic [DATA_WIDTH-1:0]       ReadDataW,
  output logic [REG_ADDR_WIDTH-1:0]   RdW,
  output logic [DATA_WIDTH-1:0]       PCPlus4W,
  output logic                        RegWriteW,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcW,
  output logic [1:0]                  Occupancy,
  output logic [STALL_CNT_WIDTH-1:0]  StallCount
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]       alu_result;
    logic [DATA_WIDTH-1:0]       read_data;
    logic [REG_ADDR_WIDTH-1:0]   rd;
    logic [DATA_WIDTH-1:0]       pc_plus4;
    logic                        reg_write;
    logic [RESULT_SRC_WIDTH-1:0] result_src;
  } payload_t;

  state_t                       state_q, state_d;
  payload_t                     main_q, main_d;
  payload_t                     skid_q, skid_d;
  payload_t                     in_dat;
  logic [STALL_CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic                         in_fire;
  logic                         out_fire;

  assign in_dat   = {ALUResultM, ReadDataM, RdM, PCPlus4M, RegWriteM, ResultSrcM};
  assign ReadyM   = (state_q != TWO);
  assign ValidW   = (state_q != EMPTY);
  assign in_fire  = ValidM & ReadyM;
  assign out_fire = ValidW & ReadyW;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_dat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_dat;
        end else if (in_fire) begin
          skid_d  = in_dat;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only drops occupancy; stale payload is masked by ValidW.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ValidM && !ReadyM && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ALUResultW = main_q.alu_result;
  assign ReadDataW  = main_q.read_data;
  assign RdW        = main_q.rd;
  assign PCPlus4W   = main_q.pc_plus4;
  assign ResultSrcW = main_q.result_src;
  // Bubbles and writes to x0 must never reach the register file.
  assign RegWriteW  = main_q.reg_write & ValidW & (main_q.rd != '0);
  assign Occupancy  = state_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Randomized bench for mem_wb_skid_reg against a queue-based FIFO reference model.
module tb_mem_wb_skid_reg;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  src;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ValidM = 1'b0;
  logic        ReadyW = 1'b0;
  logic [31:0] ALUResultM = '0, ReadDataM = '0, PCPlus4M = '0;
  logic [4:0]  RdM = '0;
  logic        RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = '0;

  logic        ReadyM, ValidW, RegWriteW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic [1:0]  ResultSrcW, Occupancy;
  logic [15:0] StallCount;

  logic        ReadyM4, ValidW4, RegWriteW4;
  logic [31:0] ALUResultW4, ReadDataW4, PCPlus4W4;
  logic [4:0]  RdW4;
  logic [1:0]  ResultSrcW4, Occupancy4;
  logic [3:0]  StallCount4;

  ent_t        mq[$];
  int unsigned m_stall = 0;
  int unsigned m_stall4 = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_wb_skid_reg u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ValidM(ValidM), .ReadyM(ReadyM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ValidW(ValidW), .ReadyW(ReadyW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .Occupancy(Occupancy),
    .StallCount(StallCount)
  );

  mem_wb_skid_reg #(.STALL_CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ValidM(ValidM), .ReadyM(ReadyM4),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ValidW(ValidW4), .ReadyW(ReadyW),
    .ALUResultW(ALUResultW4), .ReadDataW(ReadDataW4), .RdW(RdW4), .PCPlus4W(PCPlus4W4),
    .RegWriteW(RegWriteW4), .ResultSrcW(ResultSrcW4), .Occupancy(Occupancy4),
    .StallCount(StallCount4)
  );

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd, input logic rw);
    ValidM     = v;
    ALUResultM = alu;
    ReadDataM  = alu ^ 32'h5555_0000;
    PCPlus4M   = alu + 32'd4;
    RdM        = rd;
    RegWriteM  = rw;
    ResultSrcM = rd[1:0];
  endtask

  // Advance one clock edge and apply the FIFO rules to the reference model.
  task automatic tick();
    ent_t e;
    bit   inf, outf;
    e.alu = ALUResultM; e.rdata = ReadDataM; e.pc = PCPlus4M;
    e.rd = RdM; e.rw = RegWriteM; e.src = ResultSrcM;
    inf  = ValidM && (mq.size() < 2);
    outf = (mq.size() != 0) && ReadyW;
    if (ValidM && mq.size() == 2) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall4 < 15) m_stall4++;
    end
    if (flush) mq.delete();
    else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_stall  = 0;
    m_stall4 = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    total++; if (ValidW !== 1'b0) begin bad++; $display("FAIL reset_validw got=%b exp=0", ValidW); end
    total++; if (ReadyM !== 1'b1) begin bad++; $display("FAIL reset_readym got=%b exp=1", ReadyM); end
    total++; if (Occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", Occupancy); end
    total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWriteW); end
    total++; if (StallCount !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", StallCount); end
    total++; if ({ALUResultW, ReadDataW, PCPlus4W, RdW, ResultSrcW} !== '0) begin
      bad++; $display("FAIL reset_payload got=%h/%h/%h/%h/%h exp=0", ALUResultW, ReadDataW, PCPlus4W, RdW, ResultSrcW);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    ReadyW = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 32'(k * 16), 5'(k), 1'b1);
      tick();
      total++; if (ALUResultW !== 32'(k * 16) || ValidW !== 1'b1) begin
        bad++; $display("FAIL b2b_alu_%0d got=%h v=%b exp=%h v=1", k, ALUResultW, ValidW, k * 16);
      end
      total++; if (RdW !== 5'(k)) begin bad++; $display("FAIL b2b_rd_%0d got=%0d exp=%0d", k, RdW, k); end
      total++; if (ReadyM !== 1'b1 || Occupancy > 2'd1) begin
        bad++; $display("FAIL b2b_flow_%0d readym=%b occ=%0d exp readym=1 occ<=1", k, ReadyM, Occupancy);
      end
    end
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    tick();
    total++; if (ValidW !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", ValidW); end
  endtask

  task automatic test_skid();
    logic [31:0] vals[3];
    logic [31:0] seen[$];
    int          idx = 0;
    int unsigned st0;
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    ReadyW = 1'b0;
    st0 = m_stall;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      drive(1'b1, vals[idx], 5'(idx + 7), 1'b1);
      acc = (mq.size() < 2);
      tick();
      if (acc) idx++;
    end
    total++; if (Occupancy !== 2'd2 || ReadyM !== 1'b0) begin
      bad++; $display("FAIL skid_full occ=%0d readym=%b exp occ=2 readym=0", Occupancy, ReadyM);
    end
    total++; if (StallCount !== 16'(st0 + 4)) begin
      bad++; $display("FAIL skid_stall got=%0d exp=%0d", StallCount, st0 + 4);
    end
    total++; if (ALUResultW !== 32'hA) begin bad++; $display("FAIL skid_hold got=%h exp=a", ALUResultW); end
    ReadyW = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bit acc;
      if (ValidW && ReadyW) seen.push_back(ALUResultW);
      if (idx < 3) drive(1'b1, vals[idx], 5'(idx + 7), 1'b1);
      else drive(1'b0, 32'd0, 5'd0, 1'b0);
      acc = ValidM && (mq.size() < 2);
      tick();
      if (acc) idx++;
    end
    total++; if (seen.size() != 3) begin bad++; $display("FAIL skid_count got=%0d exp=3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      total++; if (seen[i] !== vals[i]) begin bad++; $display("FAIL skid_order_%0d got=%h exp=%h", i, seen[i], vals[i]); end
    end
  endtask

  task automatic test_regwrite();
    ReadyW = 1'b0;
    drive(1'b1, 32'h123, 5'd0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    total++; if (ValidW !== 1'b1 || RegWriteW !== 1'b0) begin
      bad++; $display("FAIL rw_x0 valid=%b rw=%b exp valid=1 rw=0", ValidW, RegWriteW);
    end
    ReadyW = 1'b1;
    drive(1'b1, 32'h123, 5'd5, 1'b1);
    tick();
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    total++; if (RegWriteW !== 1'b1) begin bad++; $display("FAIL rw_x5 got=%b exp=1", RegWriteW); end
    tick();
    total++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin
      bad++; $display("FAIL rw_empty valid=%b rw=%b exp 0/0", ValidW, RegWriteW);
    end
  endtask

  task automatic test_flush();
    int unsigned st0;
    ReadyW = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 32'(c + 1), 5'd3, 1'b1);
      tick();
    end
    total++; if (Occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre occ=%0d exp=2", Occupancy); end
    st0 = m_stall;
    flush = 1'b1;
    drive(1'b1, 32'hDEAD, 5'd4, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    total++; if (ValidW !== 1'b0 || Occupancy !== 2'd0 || ReadyM !== 1'b1) begin
      bad++; $display("FAIL flush_state valid=%b occ=%0d readym=%b exp 0/0/1", ValidW, Occupancy, ReadyM);
    end
    total++; if (StallCount !== 16'(st0 + 1)) begin
      bad++; $display("FAIL flush_stall got=%0d exp=%0d", StallCount, st0 + 1);
    end
    ReadyW = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (ValidW !== 1'b0) begin bad++; $display("FAIL flush_ghost_%0d got valid=%b alu=%h exp valid=0", c, ValidW, ALUResultW); end
    end
  endtask

  task automatic test_async_reset();
    ReadyW = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'(c + 32'h40), 5'd9, 1'b1);
      tick();
    end
    total++; if (Occupancy !== 2'd2 || StallCount === 16'd0) begin
      bad++; $display("FAIL arst_pre occ=%0d stall=%0d exp occ=2 stall>0", Occupancy, StallCount);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || Occupancy !== 2'd0) begin
      bad++; $display("FAIL arst_out valid=%b rw=%b occ=%0d exp 0/0/0", ValidW, RegWriteW, Occupancy);
    end
    total++; if (ReadyM !== 1'b1 || StallCount !== 16'd0 || StallCount4 !== 4'd0) begin
      bad++; $display("FAIL arst_ctl readym=%b stall=%0d stall4=%0d exp 1/0/0", ReadyM, StallCount, StallCount4);
    end
    total++; if (ALUResultW !== 32'd0 || RdW !== 5'd0) begin
      bad++; $display("FAIL arst_payload alu=%h rd=%0d exp 0/0", ALUResultW, RdW);
    end
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_stall_sat();
    ReadyW = 1'b0;
    drive(1'b1, 32'h77, 5'd1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick();
      total++; if (StallCount4 !== 4'(m_stall4)) begin
        bad++; $display("FAIL sat_step_%0d got=%0d exp=%0d", c, StallCount4, m_stall4);
      end
    end
    total++; if (StallCount4 !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d exp=15", StallCount4); end
    total++; if (StallCount !== 16'd18) begin bad++; $display("FAIL sat_wide got=%0d exp=18", StallCount); end
    drive(1'b0, 32'd0, 5'd0, 1'b0);
    ReadyW = 1'b1;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit exp_rw;
      flush      = ($urandom_range(0, 19) == 0);
      ValidM     = $urandom_range(0, 3) != 0;
      ReadyW     = $urandom_range(0, 2) != 0;
      ALUResultM = $urandom;
      ReadDataM  = $urandom;
      PCPlus4M   = $urandom;
      RdM        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      RegWriteM  = 1'($urandom);
      ResultSrcM = 2'($urandom);
      tick();
      total++; if (ValidW !== (mq.size() != 0) || Occupancy !== 2'(mq.size()) || ReadyM !== (mq.size() < 2)) begin
        bad++; $display("FAIL rnd_ctl_%0d valid=%b occ=%0d readym=%b exp occ=%0d", c, ValidW, Occupancy, ReadyM, mq.size());
      end
      total++; if (StallCount !== 16'(m_stall) || StallCount4 !== 4'(m_stall4)) begin
        bad++; $display("FAIL rnd_stall_%0d got=%0d/%0d exp=%0d/%0d", c, StallCount, StallCount4, m_stall, m_stall4);
      end
      total++; if (ValidW4 !== ValidW || Occupancy4 !== 2'(mq.size())) begin
        bad++; $display("FAIL rnd_narrow_%0d valid=%b occ=%0d exp occ=%0d", c, ValidW4, Occupancy4, mq.size());
      end
      exp_rw = (mq.size() != 0) && mq[0].rw && (mq[0].rd != 5'd0);
      total++; if (RegWriteW !== exp_rw) begin bad++; $display("FAIL rnd_rw_%0d got=%b exp=%b", c, RegWriteW, exp_rw); end
      if (mq.size() != 0) begin
        total++;
        if (ALUResultW !== mq[0].alu || ReadDataW !== mq[0].rdata || PCPlus4W !== mq[0].pc ||
            RdW !== mq[0].rd || ResultSrcW !== mq[0].src) begin
          bad++; $display("FAIL rnd_payload_%0d got=%h/%h/%h/%0d/%0d exp=%h/%h/%h/%0d/%0d", c,
                          ALUResultW, ReadDataW, PCPlus4W, RdW, ResultSrcW,
                          mq[0].alu, mq[0].rdata, mq[0].pc, mq[0].rd, mq[0].src);
        end
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_skid();
    test_regwrite();
    test_flush();
    test_async_reset();
    test_stall_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
